// File: rtl/regfile_wr_ctrl.sv
// regfile_wr_ctrl: write-port controller for the register bank.
// It shares the bank's single write port between two requesters with
// round-robin valid/ready arbitration. It also runs a bulk-clear sequencer
// that zeroes registers 1..2^N-1 without resetting the bank.
//
// Ports:
//   clk, rst_n              clock; asynchronous active-low reset
//   req0_valid/ready/addr/data
//                           requester 0 write handshake (ready is combinational)
//   req1_valid/ready/addr/data
//                           requester 1 write handshake (ready is combinational)
//   clr_start               level-sampled request to start a bulk clear
//   clr_busy                clear sequencer is running
//   clr_done                one-cycle pulse, coincident with the last clear write
//   rf_we, rf_addr_rd, rf_data_in
//                           registered write port to the bank
//   wr_cnt                  count of issued bank writes; present only when
//                           RF_WRCNT_EN is defined
//
// Optional feature macro: RF_WRCNT_EN
module regfile_wr_ctrl #(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_addr,
    input  logic [W-1:0] req0_data,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_addr,
    input  logic [W-1:0] req1_data,
    input  logic         clr_start,
    output logic         clr_busy,
    output logic         clr_done,
    output logic         rf_we,
    output logic [N-1:0] rf_addr_rd,
`ifdef RF_WRCNT_EN
    output logic [W-1:0] rf_data_in,
    output logic [15:0]  wr_cnt
`else
    output logic [W-1:0] rf_data_in
`endif
);
    typedef enum logic {IDLE, CLEAR} state_t;
    localparam logic [N-1:0] ONE  = 1;
    localparam logic [N-1:0] LAST = '1;
    state_t state, state_nxt;
    logic [N-1:0] ptr, ptr_nxt, addr_nxt;
    logic [W-1:0] data_nxt;
    logic last_grant, last_grant_nxt, we_nxt, done_nxt;
    // last_grant=1 means requester 1 won the most recent transfer, so requester 0 wins the next conflict.
    always_comb begin
        state_nxt      = state;
        ptr_nxt        = ptr;
        last_grant_nxt = last_grant;
        addr_nxt       = rf_addr_rd;
        data_nxt       = rf_data_in;
        we_nxt         = 1'b0;
        done_nxt       = 1'b0;
        req0_ready     = 1'b0;
        req1_ready     = 1'b0;
        if (state == CLEAR) begin
            we_nxt   = 1'b1;
            addr_nxt = ptr;
            data_nxt = '0;
            ptr_nxt  = ptr + ONE;
            if (ptr == LAST) begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
        end else if (clr_start) begin
            state_nxt = CLEAR;
            ptr_nxt   = ONE;
        end else begin
            req0_ready = req0_valid & (~req1_valid | last_grant);
            req1_ready = req1_valid & (~req0_valid | ~last_grant);
            // A transfer to address 0 completes the handshake but is never sent to the bank.
            if (req0_ready) begin
                last_grant_nxt = 1'b0;
                we_nxt         = |req0_addr;
                addr_nxt       = we_nxt ? req0_addr : rf_addr_rd;
                data_nxt       = we_nxt ? req0_data : rf_data_in;
            end else if (req1_ready) begin
                last_grant_nxt = 1'b1;
                we_nxt         = |req1_addr;
                addr_nxt       = we_nxt ? req1_addr : rf_addr_rd;
                data_nxt       = we_nxt ? req1_data : rf_data_in;
            end
        end
    end
    assign clr_busy = (state == CLEAR);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= ONE;
            last_grant <= 1'b1;
            rf_we      <= 1'b0;
            rf_addr_rd <= '0;
            rf_data_in <= '0;
            clr_done   <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            last_grant <= last_grant_nxt;
            rf_we      <= we_nxt;
            rf_addr_rd <= addr_nxt;
            rf_data_in <= data_nxt;
            clr_done   <= done_nxt;
        end
    end
`ifdef RF_WRCNT_EN
    // The counter advances on the same edge that raises rf_we, so it includes the write currently presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wr_cnt <= '0;
        else        wr_cnt <= wr_cnt + {15'd0, we_nxt};
    end
`endif
endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// tb_regfile_wr_ctrl: self-checking bench for regfile_wr_ctrl.
module tb_regfile_wr_ctrl;
    localparam int N = 4;
    localparam int W = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0_valid = 1'b0, req1_valid = 1'b0, clr_start = 1'b0;
    logic [N-1:0] req0_addr = '0, req1_addr = '0;
    logic [W-1:0] req0_data = '0, req1_data = '0;
    logic req0_ready, req1_ready, clr_busy, clr_done, rf_we;
    logic [N-1:0] rf_addr_rd;
    logic [W-1:0] rf_data_in;
`ifdef RF_WRCNT_EN
    logic [15:0] wr_cnt;
`endif

    regfile_wr_ctrl #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .rf_we(rf_we), .rf_addr_rd(rf_addr_rd),
`ifdef RF_WRCNT_EN
        .rf_data_in(rf_data_in), .wr_cnt(wr_cnt)
`else
        .rf_data_in(rf_data_in)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Behavioural model: pending clear addresses form a queue; the writer issues one entry per cycle.
    int q[$];
    int lg, e_we, e_addr, e_data, e_done, e_cnt;
    bit m_r0, m_r1, m_busy;
    bit s_r0, s_r1, s_we, s_busy, s_done;
    int s_addr, s_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        lg = 1; e_we = 0; e_addr = 0; e_data = 0; e_done = 0; e_cnt = 0;
    endtask

    // One clock cycle: compare at the falling edge, advance the model at the rising edge.
    task automatic step();
        @(negedge clk);
        m_busy = q.size() != 0;
        m_r0 = !m_busy && !clr_start && req0_valid && (!req1_valid || lg == 1);
        m_r1 = !m_busy && !clr_start && req1_valid && (!req0_valid || lg == 0);
        s_r0 = req0_ready; s_r1 = req1_ready; s_we = rf_we; s_busy = clr_busy; s_done = clr_done;
        s_addr = int'(rf_addr_rd); s_data = int'(rf_data_in);
        check("req0_ready", 32'(req0_ready), 32'(m_r0));
        check("req1_ready", 32'(req1_ready), 32'(m_r1));
        check("rf_we", 32'(rf_we), e_we);
        check("rf_addr_rd", 32'(rf_addr_rd), e_addr);
        check("rf_data_in", 32'(rf_data_in), e_data);
        check("clr_busy", 32'(clr_busy), 32'(m_busy));
        check("clr_done", 32'(clr_done), e_done);
`ifdef RF_WRCNT_EN
        check("wr_cnt", 32'(wr_cnt), e_cnt);
`endif
        @(posedge clk);
        if (q.size() != 0) begin
            e_addr = q.pop_front();
            e_we = 1; e_data = 0; e_done = (q.size() == 0) ? 1 : 0;
        end else begin
            e_we = 0; e_done = 0;
            if (clr_start) begin
                for (int a = 1; a < (1 << N); a++) q.push_back(a);
            end else if (m_r0) begin
                lg = 0;
                if (req0_addr != 0) begin e_we = 1; e_addr = int'(req0_addr); e_data = int'(req0_data); end
            end else if (m_r1) begin
                lg = 1;
                if (req1_addr != 0) begin e_we = 1; e_addr = int'(req1_addr); e_data = int'(req1_data); end
            end
        end
        e_cnt = (e_cnt + e_we) & 32'hFFFF;
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; clr_start = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        logic v0; logic [3:0] a0; logic [15:0] d0;
        logic v1; logic [3:0] a1; logic [15:0] d1;
        logic r0; logic r1; logic we; logic [3:0] addr; logic [15:0] data;
    } vec_t;
    vec_t tbl[11];

    initial begin
        int next_addr, nwr;
        bit seen_done;
        // Outputs in each row are those visible during that row's cycle (result of the previous row).
        tbl[0]  = '{1'b1, 4'd3, 16'hABCD, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000};
        tbl[1]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd3, 16'hABCD};
        tbl[2]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd6, 16'h0606, 1'b0, 1'b1, 1'b0, 4'd3, 16'hABCD};
        tbl[3]  = '{1'b1, 4'd2, 16'h1111, 1'b1, 4'd5, 16'h5555, 1'b1, 1'b0, 1'b1, 4'd6, 16'h0606};
        tbl[4]  = '{1'b1, 4'd2, 16'h1111, 1'b1, 4'd5, 16'h5555, 1'b0, 1'b1, 1'b1, 4'd2, 16'h1111};
        tbl[5]  = '{1'b1, 4'd2, 16'h1111, 1'b1, 4'd5, 16'h5555, 1'b1, 1'b0, 1'b1, 4'd5, 16'h5555};
        tbl[6]  = '{1'b1, 4'd2, 16'h1111, 1'b1, 4'd5, 16'h5555, 1'b0, 1'b1, 1'b1, 4'd2, 16'h1111};
        tbl[7]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 16'h1234, 1'b0, 1'b1, 1'b1, 4'd5, 16'h5555};
        tbl[8]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd5, 16'h5555};
        tbl[9]  = '{1'b1, 4'd0, 16'h7777, 1'b1, 4'd9, 16'h9999, 1'b1, 1'b0, 1'b0, 4'd5, 16'h5555};
        tbl[10] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd5, 16'h5555};

        model_reset();
        #1 check("reset_rf_we", 32'(rf_we), 0);
        check("reset_clr_busy", 32'(clr_busy), 0);
        apply_reset();
        for (int i = 0; i < 11; i++) begin
            req0_valid = tbl[i].v0; req0_addr = tbl[i].a0; req0_data = tbl[i].d0;
            req1_valid = tbl[i].v1; req1_addr = tbl[i].a1; req1_data = tbl[i].d1;
            step();
            check($sformatf("tbl%0d_r0", i), 32'(s_r0), 32'(tbl[i].r0));
            check($sformatf("tbl%0d_r1", i), 32'(s_r1), 32'(tbl[i].r1));
            check($sformatf("tbl%0d_we", i), 32'(s_we), 32'(tbl[i].we));
            check($sformatf("tbl%0d_addr", i), s_addr, 32'(tbl[i].addr));
            check($sformatf("tbl%0d_data", i), s_data, 32'(tbl[i].data));
        end

        // Clear requested alongside a req0 write: the clear wins, req0 waits it out.
        apply_reset();
        clr_start = 1'b1; req0_valid = 1'b1; req0_addr = 4'd4; req0_data = 16'h4444;
        step();
        check("clr_vs_req0_ready", 32'(s_r0), 0);
        clr_start = 1'b0;
        next_addr = 1; nwr = 0; seen_done = 0;
        for (int i = 0; i < 40 && !seen_done; i++) begin
            step();
            if (s_busy) check("clr_ready_stall", 32'(s_r0), 0);
            if (s_we) begin
                check("clr_seq_addr", s_addr, next_addr);
                check("clr_seq_data", s_data, 0);
                next_addr++; nwr++;
            end
            if (s_done) begin
                check("clr_done_addr", s_addr, 15);
                check("post_clear_accept", 32'(s_r0), 1);
                seen_done = 1;
            end
        end
        check("clr_done_seen", 32'(seen_done), 1);
        check("clr_write_count", nwr, 15);
        req0_valid = 1'b0;
        step();
        check("post_clear_addr", s_addr, 4);
        check("post_clear_data", s_data, 32'h4444);
        check("post_clear_done_low", 32'(s_done), 0);

        // Reset while the clear is at address 7, then restart the clear.
        apply_reset();
        clr_start = 1'b1; step(); clr_start = 1'b0;
        repeat (7) step();
        check("abort_point_addr", 32'(rf_addr_rd), 7);
        check("abort_point_we", 32'(rf_we), 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_we", 32'(rf_we), 0);
        check("abort_addr", 32'(rf_addr_rd), 0);
        check("abort_data", 32'(rf_data_in), 0);
        check("abort_busy", 32'(clr_busy), 0);
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(clr_done), 0);
            @(posedge clk);
        end
        #1 rst_n = 1'b1;
        clr_start = 1'b1; step(); clr_start = 1'b0;
        step(); step();
        check("restart_first_we", 32'(s_we), 1);
        check("restart_first_addr", s_addr, 1);
        seen_done = 0;
        for (int i = 0; i < 40 && !seen_done; i++) begin
            step();
            if (s_done) seen_done = 1;
        end
        check("restart_done_seen", 32'(seen_done), 1);

        // Randomized traffic with rare clears; a stalled requester holds its request.
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            if (!(req0_valid && !m_r0 && i > 0)) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_addr = 4'($urandom_range(0, 15));
                req0_data = 16'($urandom);
            end
            if (!(req1_valid && !m_r1 && i > 0)) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_addr = 4'($urandom_range(0, 15));
                req1_data = 16'($urandom);
            end
            clr_start = ($urandom_range(0, 39) == 0);
            step();
        end
        clr_start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
